seq_mul_param: RTL and testbench

Parametrised sequential shift-add multiplier, the successor to the fixed 4x4 unit. It generalises operand width to W bits and adds a per-operation signed/unsigned mode. A start/busy/done handshake lets a controller FSM or bus-attached register block issue back-to-back multiplies. One shift-add step per clock keeps area minimal; the block sits beside the ALU as a multi-cycle functional unit.

---
 rtl/mul_pkg.sv | 20 ++
 rtl/mul_sa_dp.sv | 58 +++++
 rtl/seq_mul_param.sv | 82 ++++++++
 tb/tb_seq_mul_param.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier family:
// FSM state encoding and counter sizing.
package mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

  // Step counter only has to reach W-1, so clog2(W) bits suffice.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mul_sa_dp.sv
// Shift-add datapath: magnitude load, one add/shift step per clock, and a
// final conditional two's-complement negate into the result register.
module mul_sa_dp #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           last,
  input  logic           sgn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] y
);

  localparam int P = 2 * W;

  logic [W-1:0] mcand;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic [P:0]   prod;
  logic [P:0]   prod_nxt;
  logic [W:0]   sum;
  logic         neg;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    a_mag    = a;
    b_mag    = b;
    if (sgn && a[W-1]) a_mag = ~a + W'(1);
    if (sgn && b[W-1]) b_mag = ~b + W'(1);
    // The carry bit is always 0 here (shifted in last step), so sum keeps it.
    sum      = prod[P:W] + {1'b0, mcand};
    prod_nxt = prod >> 1;
    if (prod[0]) prod_nxt = {sum, prod[W-1:0]} >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand <= '0;
      prod  <= '0;
      neg   <= 1'b0;
      y     <= '0;
    end else begin
      if (load) begin
        mcand <= a_mag;
        prod  <= {{(W+1){1'b0}}, b_mag};
        neg   <= sgn & (a[W-1] ^ b[W-1]);
      end else if (step) begin
        prod <= prod_nxt;
      end
      if (step && last)
        y <= neg ? (~prod_nxt[P-1:0] + P'(1)) : prod_nxt[P-1:0];
    end
  end

endmodule

// File: rtl/seq_mul_param.sv
// Parametrised sequential multiplier: start/busy/done handshake, W shift-add
// steps per operation, optional two's-complement mode.
module seq_mul_param
  import mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] y
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load;
  logic          step;
  logic          last;

  assign load = (state == IDLE) && start;
  assign step = (state == CALC);
  assign last = (cnt == LAST_STEP);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  mul_sa_dp #(.W(W)) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .last (last),
    .sgn  (sgn),
    .a    (a),
    .b    (b),
    .y    (y)
  );

endmodule

// File: tb/tb_seq_mul_param.sv
// Directed self-checking bench for seq_mul_param at W=4 and W=8.
module tb_seq_mul_param;

  logic        clk;
  logic        rst;
  logic        start4, sgn4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  y4;
  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] y8;

  int checks   = 0;
  int failures = 0;

  seq_mul_param #(.W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .y(y4)
  );

  seq_mul_param #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y(y8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fa(input int c);
    return 8'(c * 37 + 11);
  endfunction

  function automatic logic [7:0] fb(input int c);
    return 8'(c * 91 + 5);
  endfunction

  // One W=8 operation from IDLE: checks accept-to-done latency, product, and
  // that the unit is idle one cycle after done. Operands are scrambled after accept.
  task automatic op8(input string tag, input logic s, input logic [7:0] aa,
                     input logic [7:0] bb, input logic [15:0] exp);
    int n;
    start8 = 1'b1; sgn8 = s; a8 = aa; b8 = bb;
    tick();
    start8 = 1'b0; sgn8 = ~s; a8 = ~aa; b8 = bb + 8'd1;
    n = 0;
    while (!done8 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd8);
    check({tag, "_y"}, 64'(y8), 64'(exp));
    tick();
    check({tag, "_done_cleared"}, 64'(done8), 64'd0);
    check({tag, "_busy_cleared"}, 64'(busy8), 64'd0);
  endtask

  initial begin
    int n;
    int ndone;
    logic [15:0] held;

    rst = 1'b0;
    start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    tick(); tick(); tick();
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_done4", 64'(done4), 64'd0);
    check("rst_y4",    64'(y4),    64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_y8",    64'(y8),    64'd0);
    rst = 1'b1;
    tick();

    // W=4 unsigned 13*11: done exactly 4 cycles after accept, busy for 5.
    start4 = 1'b1; a4 = 4'd13; b4 = 4'd11;
    tick();
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    check("w4_busy_k", 64'(busy4), 64'd1);
    check("w4_done_k", 64'(done4), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("w4_busy_k%0d", i), 64'(busy4), 64'd1);
      check($sformatf("w4_done_k%0d", i), 64'(done4), (i == 4) ? 64'd1 : 64'd0);
    end
    check("w4_y", 64'(y4), 64'd143);
    tick();
    check("w4_busy_end", 64'(busy4), 64'd0);
    check("w4_done_end", 64'(done4), 64'd0);

    // W=8 signed corners and a small mixed-sign case.
    op8("s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000);
    op8("s_m128_127",  1'b1, 8'h80, 8'h7F, 16'hC080);
    op8("s_m3_5",      1'b1, 8'hFD, 8'h05, 16'hFFF1);
    // W=8 unsigned max and zero operand.
    op8("u_ff_ff",     1'b0, 8'hFF, 8'hFF, 16'hFE01);
    op8("u_0_a5",      1'b0, 8'h00, 8'hA5, 16'h0000);

    // Back-to-back with start held: accepts at c=0,10,20,...
    sgn8 = 1'b0;
    for (int c = 0; c < 32; c++) begin
      start8 = 1'b1; a8 = fa(c); b8 = fb(c);
      tick();
      check($sformatf("b2b_done_c%0d", c), 64'(done8), (c % 10 == 8) ? 64'd1 : 64'd0);
      check($sformatf("b2b_busy_c%0d", c), 64'(busy8), (c % 10 == 9) ? 64'd0 : 64'd1);
      if (c % 10 == 8)
        check($sformatf("b2b_y_c%0d", c), 64'(y8),
              64'({8'h00, fa(c - 8)} * {8'h00, fb(c - 8)}));
    end
    start8 = 1'b0;
    n = 0;
    while (busy8 && n < 20) begin
      tick();
      n++;
    end
    check("b2b_drain", 64'(busy8), 64'd0);

    // Reset after step 3 of an operation: no done, y cleared, then recovery.
    op8("pre_rst", 1'b0, 8'd200, 8'd3, 16'd600);
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd77; b8 = 8'd99;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("midrst_busy", 64'(busy8), 64'd0);
    check("midrst_done", 64'(done8), 64'd0);
    check("midrst_y",    64'(y8),    64'd0);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    op8("post_rst", 1'b0, 8'd77, 8'd99, 16'd7623);

    // Hold: y stays for 20 idle cycles and through the next op until its last step.
    held = 16'd7623;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("hold_idle_%0d", i), 64'(y8), 64'(held));
    end
    start8 = 1'b1; sgn8 = 1'b1; a8 = 8'hF9; b8 = 8'h06;
    tick();
    start8 = 1'b0;
    check("hold_accept", 64'(y8), 64'(held));
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("hold_step_%0d", i), 64'(y8), (i == 8) ? 64'hFFD6 : 64'(held));
    end
    check("hold_done", 64'(done8), 64'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
